util_trafic_generator: RTL and testbench
========================================

# util_trafic_generator

Rate-paced AXI4-Stream traffic source that emits an incrementing data pattern in fixed-length packets. It is the transmit-side partner of the traffic checker: its stream feeds a link or DMA path under test, and the far-end checker flags any beat that is not previous data + 1. It also provides single-shot error injection and beat/packet counters for link bring-up and throughput tests.

## Interface
- CLK_FREQ, 64'd150_000_000: clk frequency in Hz.
- SPEED, 64'd150_000_000: target beat rate in Hz. DIV = (CLK_FREQ/SPEED) ? CLK_FREQ/SPEED-1 : 0.
- TBYTE_NUM, 64'd16: bytes per beat.
- ID_WIDTH, 5: tid width.
- DEST_WIDTH, 5: tdest width.
- PKT_LEN, 256: beats per packet, 1..2^32-1.
- ID_VAL, 0: constant tid value.
- DEST_VAL, 0: constant tdest value.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  generation enable, level.
- inject_err  in  1  one-cycle request to corrupt the next launched beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  TBYTE_NUM*8  pattern data.
- m_axis_tkeep  out  TBYTE_NUM  constant all ones.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tid  out  ID_WIDTH  constant ID_VAL.
- m_axis_tdest  out  DEST_WIDTH  constant DEST_VAL.
- beat_cnt  out  32  accepted beats, wraps at 2^32.
- pkt_cnt  out  32  accepted beats with tlast, wraps at 2^32.
- busy  out  1  state != IDLE.

## Operation
- Pacing: 32-bit cnt and registered pulse. While en: if cnt < DIV then cnt++, pulse=0; else cnt=0, pulse=1. While !en: cnt=0, pulse=0. DIV=0 gives pulse on every cycle after the first enabled cycle.
- States: IDLE, ARM, SEND. m_axis_tvalid = (state==SEND), registered.
- IDLE -> ARM when en.
- ARM -> SEND on pulse. ARM -> IDLE when !en (priority over pulse).
- SEND, no handshake: hold. tvalid, tdata and tlast remain stable regardless of en or pulse. A pulse seen here is dropped, not accumulated.
- SEND, handshake (tvalid & tready): if en & pulse, stay SEND with the next beat; else if en, go to ARM; else go to IDLE.
- Data: pattern register seq, width TBYTE_NUM*8, resets to 1. It increments by 1 per handshake, modulo 2^(TBYTE_NUM*8), and is loaded into tdata when a beat launches.
- Error injection: inject_err sets pending flag err_pend. The next launched beat carries tdata = seq ^ 1 and clears err_pend. seq itself is unaffected, so the following beat is correct again. Multiple requests before a launch collapse to one.
- Packet framing: beat index idx, 0..PKT_LEN-1. tlast = (idx == PKT_LEN-1). idx increments on handshake and wraps to 0 after a tlast beat. With PKT_LEN=1, every beat has tlast.
- Deasserting en mid-packet finishes only the in-flight beat. idx and seq are retained, so a resumed run continues the same packet and sequence.
- Counters: beat_cnt++ on every handshake; pkt_cnt++ on every handshake with tlast. Both clear only on rst.

## Timing
- Reset values: tvalid 0, tdata 0, tlast 0 (tlast is 1 if PKT_LEN=1 once the first beat is loaded), beat_cnt 0, pkt_cnt 0, busy 0, state IDLE, seq 1, idx 0, err_pend 0, cnt 0, pulse 0.
- Reset mid-transfer: tvalid drops on the cycle after rst is sampled, even with no handshake. This AXIS violation is accepted under reset.
- First beat: en is first sampled high at edge E0; tvalid rises after edge E(DIV+1).
- Steady state with tready=1: one beat per DIV+1 cycles. DIV=0 gives back-to-back beats at 100% throughput.
- With tready low: the beat is held. Pacing keeps counting, and pulses during the stall are lost. The effective rate is never greater than SPEED.
- Output to next-beat decision is registered. There is no combinational path from tready to any output.

## Test plan
- DIV=0, PKT_LEN=4, tready=1, en held: tdata 1,2,3,4,5… on consecutive cycles. tlast on data 4, 8, 12. After 12 beats: beat_cnt=12, pkt_cnt=3.
- CLK_FREQ=100, SPEED=25 (DIV=3), tready=1: tvalid first rises after the 5th edge with en high, then one beat every 4 cycles.
- Backpressure: tready low for 10 cycles while tvalid=1: tdata and tlast stay constant, no beat skipped, and the sequence continues +1 after release.
- inject_err pulse while idle, then enable: first beat tdata=0 (1^1), next beat tdata=2. A checker flags exactly one error.
- en dropped at beat idx 2 of PKT_LEN=4 with tready low: the beat completes on tready, then busy=0. On re-enable, the next beats have idx 3 (tlast), then 0.
- rst asserted during a stalled beat with seq=0x55: next cycle tvalid=0, counters are 0, and after re-enable the first tdata=1.

Source files
------------

// File: rtl/util_trafic_generator_if.sv
// ============================================================================
// Module   : util_trafic_generator_if
// Brief    : AXI4-Stream bundle carried between the traffic generator and its sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface util_trafic_generator_if #(
    parameter int TBYTE_NUM  = 16,
    parameter int ID_WIDTH   = 5,
    parameter int DEST_WIDTH = 5
);
    logic                    tvalid;
    logic                    tready;
    logic [TBYTE_NUM*8-1:0]  tdata;
    logic [TBYTE_NUM-1:0]    tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/util_trafic_generator.sv
// ============================================================================
// Module   : util_trafic_generator
// Brief    : Rate-paced AXI4-Stream source of incrementing data in fixed-length
//            packets, with single-shot error injection and beat/packet counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module util_trafic_generator #(
    parameter logic [63:0]           CLK_FREQ   = 64'd150_000_000,
    parameter logic [63:0]           SPEED      = 64'd150_000_000,
    parameter logic [63:0]           TBYTE_NUM  = 64'd16,
    parameter int                    ID_WIDTH   = 5,
    parameter int                    DEST_WIDTH = 5,
    parameter logic [31:0]           PKT_LEN    = 32'd256,
    parameter logic [ID_WIDTH-1:0]   ID_VAL     = '0,
    parameter logic [DEST_WIDTH-1:0] DEST_VAL   = '0
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   en,
    input  wire logic                   inject_err,
    util_trafic_generator_if.master     m_axis,
    output logic [31:0]                 beat_cnt,
    output logic [31:0]                 pkt_cnt,
    output logic                        busy
);

    localparam int          c_dw    = 8 * int'(TBYTE_NUM);
    localparam logic [63:0] c_ratio = CLK_FREQ / SPEED;
    localparam logic [31:0] c_div   = (c_ratio != 64'd0) ? (c_ratio[31:0] - 32'd1) : 32'd0;
    localparam logic [31:0] c_last  = PKT_LEN - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       cnt_q;
    logic              pulse_q;
    logic [c_dw-1:0]   seq_q;
    logic [c_dw-1:0]   tdata_q;
    logic [31:0]       idx_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              err_pend_q;
    logic [31:0]       beat_cnt_q;
    logic [31:0]       pkt_cnt_q;

    logic              hs;
    logic              launch;
    logic              err_now;
    logic [c_dw-1:0]   seq_d;
    logic [31:0]       idx_d;

    assign hs = tvalid_q & m_axis.tready;

    // A beat launches from ARM on a pulse, or back-to-back when a handshake
    // coincides with a pulse; a pulse during a stall is simply lost.
    assign launch = en & pulse_q &
                    ((state_q == S_ARM) | ((state_q == S_SEND) & hs));

    // Pattern and index as they stand after this cycle's handshake.
    assign seq_d   = hs ? (seq_q + c_dw'(1)) : seq_q;
    assign idx_d   = hs ? (tlast_q ? 32'd0 : (idx_q + 32'd1)) : idx_q;
    assign err_now = err_pend_q | inject_err;

    // Rate pacing
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 32'd0;
            pulse_q <= 1'b0;
        end else if (en) begin
            if (cnt_q < c_div) begin
                cnt_q   <= cnt_q + 32'd1;
                pulse_q <= 1'b0;
            end else begin
                cnt_q   <= 32'd0;
                pulse_q <= 1'b1;
            end
        end else begin
            cnt_q   <= 32'd0;
            pulse_q <= 1'b0;
        end
    end

    // Control FSM with registered tvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                    end else if (pulse_q) begin
                        state_q  <= S_SEND;
                        tvalid_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        if (en && pulse_q) begin
                            state_q <= S_SEND;
                        end else if (en) begin
                            state_q  <= S_ARM;
                            tvalid_q <= 1'b0;
                        end else begin
                            state_q  <= S_IDLE;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: pattern, framing, injection and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q      <= c_dw'(1);
            tdata_q    <= '0;
            idx_q      <= 32'd0;
            tlast_q    <= 1'b0;
            err_pend_q <= 1'b0;
            beat_cnt_q <= 32'd0;
            pkt_cnt_q  <= 32'd0;
        end else begin
            seq_q <= seq_d;
            idx_q <= idx_d;
            if (launch) begin
                tdata_q    <= seq_d ^ {{(c_dw-1){1'b0}}, err_now};
                tlast_q    <= (idx_d == c_last);
                err_pend_q <= 1'b0;
            end else if (inject_err) begin
                err_pend_q <= 1'b1;
            end
            if (hs) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
                if (tlast_q) begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                end
            end
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tkeep  = '1;
    assign m_axis.tid    = ID_VAL;
    assign m_axis.tdest  = DEST_VAL;

    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_util_trafic_generator.sv
// ============================================================================
// Module   : tb_util_trafic_generator
// Brief    : Directed bench for the traffic generator with a beat scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_util_trafic_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b1, a_en = 1'b0, a_inj = 1'b0;
    logic b_rst = 1'b1, b_en = 1'b0, b_inj = 1'b0;
    logic [31:0] a_beat, a_pkt, b_beat, b_pkt;
    logic a_busy, b_busy;

    util_trafic_generator_if #(.TBYTE_NUM(16), .ID_WIDTH(5), .DEST_WIDTH(5)) a_if ();
    util_trafic_generator_if #(.TBYTE_NUM(2),  .ID_WIDTH(5), .DEST_WIDTH(5)) b_if ();

    util_trafic_generator #(
        .CLK_FREQ(64'd150_000_000), .SPEED(64'd150_000_000), .TBYTE_NUM(64'd16),
        .ID_WIDTH(5), .DEST_WIDTH(5), .PKT_LEN(32'd4), .ID_VAL(5'd3), .DEST_VAL(5'd5)
    ) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .inject_err(a_inj), .m_axis(a_if.master),
        .beat_cnt(a_beat), .pkt_cnt(a_pkt), .busy(a_busy)
    );

    util_trafic_generator #(
        .CLK_FREQ(64'd100), .SPEED(64'd25), .TBYTE_NUM(64'd2),
        .ID_WIDTH(5), .DEST_WIDTH(5), .PKT_LEN(32'd1), .ID_VAL(5'd0), .DEST_VAL(5'd0)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .inject_err(b_inj), .m_axis(b_if.master),
        .beat_cnt(b_beat), .pkt_cnt(b_pkt), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;
    logic [128:0] qa[$];
    logic [128:0] qb[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [127:0] d, input logic l);
        qa.push_back({l, d});
    endtask

    // Score any beat that handshakes on the coming edge, then advance one cycle.
    task automatic tick();
        logic [128:0] e;
        if (a_if.tvalid && a_if.tready) begin
            checks++;
            assert (qa.size() > 0) else begin
                errors++;
                $error("FAIL a_extra_beat observed=%0h expected=none", a_if.tdata);
            end
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_tdata", a_if.tdata, e[127:0]);
                chk("a_tlast", 128'(a_if.tlast), 128'(e[128]));
            end
        end
        if (b_if.tvalid && b_if.tready) begin
            checks++;
            assert (qb.size() > 0) else begin
                errors++;
                $error("FAIL b_extra_beat observed=%0h expected=none", b_if.tdata);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_tdata", 128'(b_if.tdata), e[127:0]);
                chk("b_tlast", 128'(b_if.tlast), 128'(e[128]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.tready = 1'b0;
        b_if.tready = 1'b0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        chk("rst_tvalid", 128'(a_if.tvalid), 128'd0);
        chk("rst_tdata",  a_if.tdata, 128'd0);
        chk("rst_tlast",  128'(a_if.tlast), 128'd0);
        chk("rst_beat",   128'(a_beat), 128'd0);
        chk("rst_pkt",    128'(a_pkt), 128'd0);
        chk("rst_busy",   128'(a_busy), 128'd0);
        chk("tkeep",      128'(a_if.tkeep), 128'hFFFF);
        chk("tid",        128'(a_if.tid), 128'd3);
        chk("tdest",      128'(a_if.tdest), 128'd5);
        chk("b_rst_tlast", 128'(b_if.tlast), 128'd0);

        // Back-to-back beats 1..12 in packets of four
        for (int k = 1; k <= 12; k++) push_a(128'(k), (k % 4) == 0);
        a_if.tready = 1'b1;
        a_en = 1'b1;
        tick();
        chk("first_lat_lo", 128'(a_if.tvalid), 128'd0);
        tick();
        chk("first_lat_hi", 128'(a_if.tvalid), 128'd1);
        repeat (11) begin
            tick();
            chk("b2b_tvalid", 128'(a_if.tvalid), 128'd1);
        end
        a_en = 1'b0;
        tick();
        chk("run12_tvalid", 128'(a_if.tvalid), 128'd0);
        chk("run12_beat",   128'(a_beat), 128'd12);
        chk("run12_pkt",    128'(a_pkt), 128'd3);
        chk("run12_busy",   128'(a_busy), 128'd0);

        // Backpressure: beat 13 held for ten cycles
        for (int k = 13; k <= 17; k++) push_a(128'(k), (k % 4) == 0);
        a_if.tready = 1'b0;
        a_en = 1'b1;
        tick();
        tick();
        repeat (10) begin
            tick();
            chk("stall_tvalid", 128'(a_if.tvalid), 128'd1);
            chk("stall_tdata",  a_if.tdata, 128'd13);
            chk("stall_tlast",  128'(a_if.tlast), 128'd0);
        end
        a_if.tready = 1'b1;
        repeat (4) tick();
        a_en = 1'b0;
        tick();
        chk("bp_beat", 128'(a_beat), 128'd17);
        chk("bp_pkt",  128'(a_pkt), 128'd4);

        // Error injected while idle corrupts only the next beat
        a_inj = 1'b1;
        tick();
        a_inj = 1'b0;
        tick();
        chk("inj_idle_tvalid", 128'(a_if.tvalid), 128'd0);
        push_a(128'(18 ^ 1), 1'b0);
        push_a(128'd19, 1'b0);
        push_a(128'd20, 1'b1);
        a_en = 1'b1;
        repeat (4) tick();
        a_en = 1'b0;
        tick();
        chk("inj_beat", 128'(a_beat), 128'd20);
        chk("inj_pkt",  128'(a_pkt), 128'd5);

        // en dropped while beat idx 2 is stalled; resume continues the packet
        push_a(128'd21, 1'b0);
        push_a(128'd22, 1'b0);
        push_a(128'd23, 1'b0);
        a_en = 1'b1;
        repeat (4) tick();
        a_if.tready = 1'b0;
        a_en = 1'b0;
        repeat (3) tick();
        chk("drop_tvalid", 128'(a_if.tvalid), 128'd1);
        chk("drop_tdata",  a_if.tdata, 128'd23);
        chk("drop_busy",   128'(a_busy), 128'd1);
        a_if.tready = 1'b1;
        tick();
        chk("drop_idle_busy",   128'(a_busy), 128'd0);
        chk("drop_idle_tvalid", 128'(a_if.tvalid), 128'd0);
        push_a(128'd24, 1'b1);
        push_a(128'd25, 1'b0);
        a_en = 1'b1;
        repeat (3) tick();
        a_en = 1'b0;
        tick();
        chk("resume_beat", 128'(a_beat), 128'd25);
        chk("resume_pkt",  128'(a_pkt), 128'd6);

        // Run up to a stalled beat 0x55, then reset mid-transfer
        for (int k = 26; k <= 84; k++) push_a(128'(k), (k % 4) == 0);
        a_en = 1'b1;
        repeat (61) tick();
        a_if.tready = 1'b0;
        repeat (2) tick();
        chk("pre_rst_tvalid", 128'(a_if.tvalid), 128'd1);
        chk("pre_rst_tdata",  a_if.tdata, 128'h55);
        a_rst = 1'b1;
        a_en = 1'b0;
        tick();
        chk("mid_rst_tvalid", 128'(a_if.tvalid), 128'd0);
        chk("mid_rst_tdata",  a_if.tdata, 128'd0);
        chk("mid_rst_beat",   128'(a_beat), 128'd0);
        chk("mid_rst_pkt",    128'(a_pkt), 128'd0);
        chk("mid_rst_busy",   128'(a_busy), 128'd0);
        a_rst = 1'b0;
        a_inj = 1'b1;
        tick();
        a_inj = 1'b0;
        push_a(128'd0, 1'b0);
        push_a(128'd2, 1'b0);
        push_a(128'd3, 1'b0);
        push_a(128'd4, 1'b1);
        a_if.tready = 1'b1;
        a_en = 1'b1;
        repeat (5) tick();
        a_en = 1'b0;
        tick();
        chk("post_rst_beat", 128'(a_beat), 128'd4);
        chk("post_rst_pkt",  128'(a_pkt), 128'd1);

        // DIV=3, PKT_LEN=1: first beat after the 5th edge, then every 4 cycles
        for (int k = 1; k <= 4; k++) qb.push_back({1'b1, 128'(k)});
        b_if.tready = 1'b1;
        b_en = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            tick();
            chk("b_pace_tvalid", 128'(b_if.tvalid), 128'((i >= 4) && ((i % 4) == 0)));
        end
        b_en = 1'b0;
        tick();
        chk("b_end_tvalid", 128'(b_if.tvalid), 128'd0);
        chk("b_beat",       128'(b_beat), 128'd4);
        chk("b_pkt",        128'(b_pkt), 128'd4);

        chk("a_sb_empty", 128'(qa.size()), 128'd0);
        chk("b_sb_empty", 128'(qb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
